// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: mem_op encodings, bus FSM
// states, common constants and small op-classification helpers.
package mem_access_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } bus_state_e;

    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic [31:0] ZERO         = 32'h0000_0000;
    localparam logic [4:0]  ZERO_REG     = 5'd0;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op,
                                           input logic [1:0] addr_lo);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: combinational lane logic for the memory stage.
//   op          : mem_op of the current instruction
//   addr_lo     : byte offset within the word
//   store_data  : rs2 store data
//   load_word   : captured bus read word
//   wdata       : lane-replicated store data (0 for non-stores)
//   be          : byte enables (4'b1111 for loads)
//   load_result : selected and sign/zero-extended load value
module mem_align
    import mem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (addr_lo)
            2'd0:    sel_byte = load_word[7:0];
            2'd1:    sel_byte = load_word[15:8];
            2'd2:    sel_byte = load_word[23:16];
            default: sel_byte = load_word[31:24];
        endcase
        sel_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        wdata       = ZERO;
        be          = 4'b1111;
        load_result = ZERO;
        case (mem_op_e'(op))
            MEM_SB: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            MEM_SH: begin
                wdata = {2{store_data[15:0]}};
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            MEM_SW:  wdata       = store_data;
            MEM_LB:  load_result = {{24{sel_byte[7]}}, sel_byte};
            MEM_LBU: load_result = {24'h0, sel_byte};
            MEM_LH:  load_result = {{16{sel_half[15]}}, sel_half};
            MEM_LHU: load_result = {16'h0, sel_half};
            MEM_LW:  load_result = load_word;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage of the RV32 pipeline (between exe_mem and mem_wb).
//   clk_in / reset_in         : clock, synchronous active-high reset
//   reg_* / csr_* inputs      : registered execute results
//   mem_we/addr/data/op_in    : load/store request from execute
//   bus_*_out / bus_*_in      : single-outstanding data-bus handshake
//   reg_* / csr_* outputs     : writeback toward mem_wb
//   stall_req_out             : holds the pipeline while an access is in flight
//   misalign_out              : misaligned-access flag
//   bus_err_out               : one-cycle pulse when the response times out
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] reg_wdata_in,
    input  logic [4:0]  reg_waddr_in,
    input  logic        reg_we_in,
    input  logic        csr_we_in,
    input  logic [31:0] csr_wdata_in,
    input  logic [11:0] csr_waddr_in,
    input  logic        mem_we_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_data_in,
    input  logic [3:0]  mem_op_in,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    output logic [3:0]  bus_be_out,
    input  logic        bus_gnt_in,
    input  logic        bus_rvalid_in,
    input  logic [31:0] bus_rdata_in,
    output logic [31:0] reg_wdata_out,
    output logic [4:0]  reg_waddr_out,
    output logic        reg_we_out,
    output logic        csr_we_out,
    output logic [31:0] csr_wdata_out,
    output logic [11:0] csr_waddr_out,
    output logic        stall_req_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    bus_state_e          state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [31:0]          rdata_q;

    logic        op_load;
    logic        op_store;
    logic        op_mem;
    logic        misaligned;
    logic [31:0] align_wdata;
    logic [3:0]  align_be;
    logic [31:0] load_result;

    // mem_we_in is implied by the op encoding; the op is authoritative.
    logic        unused_we;
    assign unused_we = mem_we_in;

    assign op_load    = is_load(mem_op_in);
    assign op_store   = is_store(mem_op_in);
    assign op_mem     = op_load || op_store;
    assign misaligned = is_misaligned(mem_op_in, mem_addr_in[1:0]);

    // exe_mem inputs stay stable while stalled, so the live op/address
    // serve both the store lanes in IDLE and the load extract in DONE.
    mem_align u_align (
        .op          (mem_op_in),
        .addr_lo     (mem_addr_in[1:0]),
        .store_data  (mem_data_in),
        .load_word   (rdata_q),
        .wdata       (align_wdata),
        .be          (align_be),
        .load_result (load_result)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= IDLE;
            cnt           <= '0;
            rdata_q       <= '0;
            bus_req_out   <= 1'b0;
            bus_we_out    <= 1'b0;
            bus_addr_out  <= '0;
            bus_wdata_out <= '0;
            bus_be_out    <= '0;
            bus_err_out   <= 1'b0;
        end else begin
            bus_err_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_mem && !misaligned) begin
                        state         <= REQ;
                        bus_req_out   <= 1'b1;
                        bus_we_out    <= op_store;
                        bus_addr_out  <= {mem_addr_in[31:2], 2'b00};
                        bus_wdata_out <= align_wdata;
                        bus_be_out    <= align_be;
                    end
                end
                REQ: begin
                    if (bus_gnt_in) begin
                        state       <= WAIT_RSP;
                        bus_req_out <= 1'b0;
                        cnt         <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (bus_rvalid_in) begin
                        rdata_q <= bus_rdata_in;
                        state   <= DONE;
                    end else if (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        bus_err_out <= 1'b1;
                        rdata_q     <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_wdata_out = ZERO;
        reg_waddr_out = ZERO_REG;
        reg_we_out    = 1'b0;
        csr_we_out    = 1'b0;
        csr_wdata_out = ZERO;
        csr_waddr_out = '0;
        stall_req_out = 1'b0;
        misalign_out  = 1'b0;
        if (!reset_in) begin
            csr_we_out    = csr_we_in;
            csr_wdata_out = csr_wdata_in;
            csr_waddr_out = csr_waddr_in;
            reg_waddr_out = reg_waddr_in;
            case (state)
                IDLE: begin
                    if (!op_mem) begin
                        reg_wdata_out = reg_wdata_in;
                        reg_we_out    = reg_we_in;
                    end else if (misaligned) begin
                        misalign_out = 1'b1;
                    end else begin
                        stall_req_out = 1'b1;
                    end
                end
                REQ, WAIT_RSP: stall_req_out = 1'b1;
                DONE: begin
                    if (op_load) begin
                        reg_wdata_out = load_result;
                        reg_we_out    = reg_we_in && WRITE_ENABLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] reg_wdata_in;
    logic [4:0]  reg_waddr_in;
    logic        reg_we_in;
    logic        csr_we_in;
    logic [31:0] csr_wdata_in;
    logic [11:0] csr_waddr_in;
    logic        mem_we_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_op_in;
    logic        bus_req_out;
    logic        bus_we_out;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_wdata_out;
    logic [3:0]  bus_be_out;
    logic        bus_gnt_in;
    logic        bus_rvalid_in;
    logic [31:0] bus_rdata_in;
    logic [31:0] reg_wdata_out;
    logic [4:0]  reg_waddr_out;
    logic        reg_we_out;
    logic        csr_we_out;
    logic [31:0] csr_wdata_out;
    logic [11:0] csr_waddr_out;
    logic        stall_req_out;
    logic        misalign_out;
    logic        bus_err_out;

    always #5 clk_in = ~clk_in;

    mem_access #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .reg_wdata_in  (reg_wdata_in),
        .reg_waddr_in  (reg_waddr_in),
        .reg_we_in     (reg_we_in),
        .csr_we_in     (csr_we_in),
        .csr_wdata_in  (csr_wdata_in),
        .csr_waddr_in  (csr_waddr_in),
        .mem_we_in     (mem_we_in),
        .mem_addr_in   (mem_addr_in),
        .mem_data_in   (mem_data_in),
        .mem_op_in     (mem_op_in),
        .bus_req_out   (bus_req_out),
        .bus_we_out    (bus_we_out),
        .bus_addr_out  (bus_addr_out),
        .bus_wdata_out (bus_wdata_out),
        .bus_be_out    (bus_be_out),
        .bus_gnt_in    (bus_gnt_in),
        .bus_rvalid_in (bus_rvalid_in),
        .bus_rdata_in  (bus_rdata_in),
        .reg_wdata_out (reg_wdata_out),
        .reg_waddr_out (reg_waddr_out),
        .reg_we_out    (reg_we_out),
        .csr_we_out    (csr_we_out),
        .csr_wdata_out (csr_wdata_out),
        .csr_waddr_out (csr_waddr_out),
        .stall_req_out (stall_req_out),
        .misalign_out  (misalign_out),
        .bus_err_out   (bus_err_out)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        logic        we;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        mem_op_in     = MEM_NOP;
        mem_we_in     = 1'b0;
        mem_addr_in   = 32'h0;
        mem_data_in   = 32'h0;
        reg_we_in     = 1'b0;
        bus_gnt_in    = 1'b0;
        bus_rvalid_in = 1'b0;
    endtask

    // Drives one load/store and acts as the bus slave; expected writeback
    // goes into the scoreboard at drive time and is popped in DONE.
    task automatic access(input string tag, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int gnt_delay,
                          input bit respond, input bit spurious,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_result,
                          input int exp_stall);
        exp_t        e;
        exp_t        got;
        int          stall_cnt  = 0;
        int          req_cycles = 0;
        bit          granted    = 0;
        bit          done       = 0;
        bit          held_ok    = 1;
        bit          store;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  b0;
        logic        we0;
        store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
        @(posedge clk_in); #1;
        mem_op_in    = op;
        mem_we_in    = store;
        mem_addr_in  = addr;
        mem_data_in  = data;
        reg_we_in    = 1'b1;
        reg_wdata_in = 32'h5555_0000;
        reg_waddr_in = 5'd7;
        e.is_load = !store;
        e.data    = exp_result;
        e.we      = !store;
        e.err     = !respond;
        sb.push_back(e);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk_in);
            bus_gnt_in    = 1'b0;
            bus_rvalid_in = 1'b0;
            if (!stall_req_out) begin
                done = 1;
            end else begin
                stall_cnt++;
                if (bus_req_out) begin
                    if (req_cycles == 0) begin
                        a0 = bus_addr_out; b0 = bus_be_out; w0 = bus_wdata_out; we0 = bus_we_out;
                        check({tag, "_addr"}, bus_addr_out, exp_addr);
                        check({tag, "_be"}, {28'h0, bus_be_out}, {28'h0, exp_be});
                        check({tag, "_we"}, {31'h0, bus_we_out}, {31'h0, store});
                        if (store) check({tag, "_wdata"}, bus_wdata_out, exp_wdata);
                    end else if (bus_addr_out !== a0 || bus_be_out !== b0 ||
                                 bus_wdata_out !== w0 || bus_we_out !== we0) begin
                        held_ok = 0;
                    end
                    req_cycles++;
                    if (req_cycles > gnt_delay) begin
                        bus_gnt_in = 1'b1;
                        granted    = 1;
                    end else if (spurious) begin
                        bus_rvalid_in = 1'b1;
                        bus_rdata_in  = 32'hDEAD_BEEF;
                    end
                end else if (granted) begin
                    bus_rvalid_in = respond;
                    bus_rdata_in  = rdata;
                end
            end
        end
        check({tag, "_finished"}, {31'h0, done}, 32'h1);
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_held"}, {31'h0, held_ok}, 32'h1);
        check({tag, "_sb_nonempty"}, {31'h0, (sb.size() > 0)}, 32'h1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            if (got.is_load) check({tag, "_rdata"}, reg_wdata_out, got.data);
            check({tag, "_reg_we"}, {31'h0, reg_we_out}, {31'h0, got.we});
            check({tag, "_err"}, {31'h0, bus_err_out}, {31'h0, got.err});
        end
        check({tag, "_waddr"}, {27'h0, reg_waddr_out}, 32'd7);
        @(posedge clk_in); #1;
        drive_nop();
        @(negedge clk_in);
        check({tag, "_err_clear"}, {31'h0, bus_err_out}, 32'h0);
        check({tag, "_req_idle"}, {31'h0, bus_req_out}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in     = 1'b1;
        reg_wdata_in = 32'h0000_1234;
        reg_waddr_in = 5'd3;
        csr_we_in    = 1'b0;
        csr_wdata_in = 32'h0;
        csr_waddr_in = 12'h0;
        bus_rdata_in = 32'h0;
        drive_nop();
        reg_we_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check("rst_reg_wdata", reg_wdata_out, 32'h0);
        check("rst_reg_we", {31'h0, reg_we_out}, 32'h0);
        check("rst_waddr", {27'h0, reg_waddr_out}, 32'h0);
        check("rst_bus_req", {31'h0, bus_req_out}, 32'h0);
        check("rst_stall", {31'h0, stall_req_out}, 32'h0);

        // ADD pass-through
        reset_in     = 1'b0;
        reg_wdata_in = 32'h0000_0005;
        reg_we_in    = 1'b1;
        reg_waddr_in = 5'd3;
        csr_we_in    = 1'b1;
        csr_wdata_in = 32'h0000_ABCD;
        csr_waddr_in = 12'h300;
        #1;
        check("nop_wdata", reg_wdata_out, 32'h5);
        check("nop_we", {31'h0, reg_we_out}, 32'h1);
        check("nop_waddr", {27'h0, reg_waddr_out}, 32'd3);
        check("nop_stall", {31'h0, stall_req_out}, 32'h0);
        check("nop_csr_wdata", csr_wdata_out, 32'h0000_ABCD);
        check("nop_csr_waddr", {20'h0, csr_waddr_out}, 32'h300);
        check("nop_csr_we", {31'h0, csr_we_out}, 32'h1);
        repeat (3) begin
            @(negedge clk_in);
            check("nop_no_req", {31'h0, bus_req_out}, 32'h0);
        end
        csr_we_in = 1'b0;

        access("sb", MEM_SB, 32'h1003, 32'h0000_00A5, 32'h0, 0, 1, 0,
               32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 3);
        access("lb", MEM_LB, 32'h2002, 32'h0, 32'h1280_FF34, 2, 1, 1,
               32'h2000, 4'b1111, 32'h0, 32'hFFFF_FF80, 5);
        access("lbu", MEM_LBU, 32'h2002, 32'h0, 32'h1280_FF34, 2, 1, 0,
               32'h2000, 4'b1111, 32'h0, 32'h0000_0080, 5);
        access("lh_hi", MEM_LH, 32'h2002, 32'h0, 32'h1280_FF34, 0, 1, 0,
               32'h2000, 4'b1111, 32'h0, 32'h0000_1280, 3);
        access("lh_lo", MEM_LH, 32'h2000, 32'h0, 32'h1280_FF34, 0, 1, 0,
               32'h2000, 4'b1111, 32'h0, 32'hFFFF_FF34, 3);
        access("lhu_lo", MEM_LHU, 32'h2000, 32'h0, 32'h1280_FF34, 0, 1, 0,
               32'h2000, 4'b1111, 32'h0, 32'h0000_FF34, 3);
        access("sh", MEM_SH, 32'h1002, 32'h1234_BEEF, 32'h0, 1, 1, 0,
               32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 4);
        access("sb_lane1", MEM_SB, 32'h1001, 32'h0000_003C, 32'h0, 0, 1, 0,
               32'h1000, 4'b0010, 32'h3C3C_3C3C, 32'h0, 3);
        access("lw", MEM_LW, 32'h3000, 32'h0, 32'h89AB_CDEF, 0, 1, 0,
               32'h3000, 4'b1111, 32'h0, 32'h89AB_CDEF, 3);

        // misaligned LW and SH
        @(posedge clk_in); #1;
        mem_op_in   = MEM_LW;
        mem_addr_in = 32'h3002;
        reg_we_in   = 1'b1;
        @(negedge clk_in);
        check("mis_lw_flag", {31'h0, misalign_out}, 32'h1);
        check("mis_lw_we", {31'h0, reg_we_out}, 32'h0);
        check("mis_lw_stall", {31'h0, stall_req_out}, 32'h0);
        check("mis_lw_req", {31'h0, bus_req_out}, 32'h0);
        @(negedge clk_in);
        check("mis_lw_req2", {31'h0, bus_req_out}, 32'h0);
        mem_op_in   = MEM_SH;
        mem_we_in   = 1'b1;
        mem_addr_in = 32'h1001;
        #1;
        check("mis_sh_flag", {31'h0, misalign_out}, 32'h1);
        @(negedge clk_in);
        check("mis_sh_req", {31'h0, bus_req_out}, 32'h0);
        drive_nop();
        #1;
        check("nop_no_misalign", {31'h0, misalign_out}, 32'h0);

        // timeout: rvalid never returns
        access("lw_timeout", MEM_LW, 32'h3000, 32'h0, 32'h1111_1111, 0, 0, 0,
               32'h3000, 4'b1111, 32'h0, 32'h0, 18);

        // reset during WAIT_RSP
        @(posedge clk_in); #1;
        mem_op_in    = MEM_LW;
        mem_addr_in  = 32'h4000;
        reg_we_in    = 1'b1;
        reg_waddr_in = 5'd7;
        @(negedge clk_in);
        @(negedge clk_in);
        check("rstw_req", {31'h0, bus_req_out}, 32'h1);
        bus_gnt_in = 1'b1;
        @(negedge clk_in);
        bus_gnt_in = 1'b0;
        check("rstw_wait_stall", {31'h0, stall_req_out}, 32'h1);
        @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        check("rstw_bus_req", {31'h0, bus_req_out}, 32'h0);
        check("rstw_stall", {31'h0, stall_req_out}, 32'h0);
        check("rstw_wdata", reg_wdata_out, 32'h0);
        check("rstw_we", {31'h0, reg_we_out}, 32'h0);
        check("rstw_waddr", {27'h0, reg_waddr_out}, 32'h0);
        check("rstw_addr", bus_addr_out, 32'h0);
        check("rstw_be", {28'h0, bus_be_out}, 32'h0);
        check("rstw_err", {31'h0, bus_err_out}, 32'h0);
        reset_in = 1'b0;
        drive_nop();
        @(negedge clk_in);
        check("rstw_idle_stall", {31'h0, stall_req_out}, 32'h0);
        access("sw_after_rst", MEM_SW, 32'h1004, 32'hCAFE_F00D, 32'h0, 0, 1, 0,
               32'h1004, 4'b1111, 32'hCAFE_F00D, 32'h0, 3);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
